instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the single-cycle/multi-cycle MIPS datapath. It holds the PC, requests words from instruction memory over a req/ack handshake, and presents each fetched instruction (with its opcode split out) to the control decoder. It consumes the decoder's jump/branch outputs to select the next PC. It sits between instruction memory and the Control/register-file stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  leave IDLE and begin fetching; sampled only in IDLE
- imem_req_o  out  1  instruction memory request
- imem_addr_o  out  32  byte address of requested word (always current PC)
- imem_ack_i  in  1  memory returns imem_data_i this cycle
- imem_data_i  in  32  instruction word, valid when imem_ack_i=1
- instr_valid_o  out  1  instr_o/op_o/pc4_o hold a fetched instruction
- instr_ready_i  in  1  downstream accepts the presented instruction
- instr_o  out  32  latched instruction word
- op_o  out  6  instr_o[31:26], feeds decoder Op_i
- pc4_o  out  32  address of presented instruction + 4
- jump_i  in  1  decoder Jump for presented instruction
- branch_i  in  1  decoder Branch for presented instruction
- zero_i  in  1  ALU zero for presented instruction
- fetch_cnt_o  out  32  number of instructions accepted since reset

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: imem_req_o=0, instr_valid_o=0. start_i=1 -> FETCH.
- FETCH: imem_req_o=1, imem_addr_o=pc. imem_ack_i=1 -> latch imem_data_i into instr register, pc4 <= pc+4, -> HOLD. Otherwise stay; address held stable.
- HOLD: instr_valid_o=1, imem_req_o=0. instr_ready_i=1 -> pc <= next_pc, fetch_cnt +1, -> FETCH. Otherwise hold all outputs stable.
- next_pc priority: jump_i=1 -> {pc4[31:28], instr[25:0], 2'b00}; else branch_i&zero_i -> pc4 + ({{14{instr[15]}}, instr[15:0], 2'b00}); else pc4.
- jump_i/branch_i/zero_i sampled only in HOLD on the accept cycle; ignored elsewhere.
- All PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. Branch offset sign-extended; negative offsets wrap likewise.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- imem_ack_i outside FETCH ignored (no latch, no state change).
- start_i outside IDLE ignored.
- No program-end detection; once started, fetching continues until reset.

## Timing
- Reset (rst_i=1 at edge): state=IDLE, pc=RESET_PC, instr=0, pc4=0, fetch_cnt=0. Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, op_o=0, pc4_o=0, fetch_cnt_o=0.
- Reset has priority over every other input in the same cycle, including in-flight FETCH with imem_ack_i=1; that data is discarded.
- start_i at edge N -> imem_req_o=1 in cycle N+1.
- imem_ack_i=1 at edge M -> instr_valid_o=1 in cycle M+1 (one-cycle registered latency).
- instr_ready_i=1 at edge K -> instr_valid_o=0 and imem_req_o=1 with new pc in cycle K+1.
- Zero-wait memory (ack in first FETCH cycle) + always-ready consumer: one instruction per 2 cycles.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

## Test plan
- Reset then start_i, memory acks immediately with 32'h8C01_0004 (lw) at addr 0, ready=1 -> op_o=6'b100011, pc4_o=4, next imem_addr_o=4, fetch_cnt_o=1.
- Memory delays ack 3 cycles -> imem_req_o stays 1 and imem_addr_o stable for 3 cycles; instr_valid_o rises exactly one cycle after ack.
- Present beq at pc=8, imm=16'hFFFE, branch_i=1, zero_i=1 -> next fetch addr 12+(-8)=4; same with zero_i=0 -> next addr 12.
- Present j at pc=32'h1000_0000, instr[25:0]=26'h000_0040, jump_i=1 and branch_i=1 -> next addr 32'h1000_0100 (jump wins).
- Hold instr_ready_i=0 for 5 cycles in HOLD, toggle imem_ack_i -> instr_o/pc4_o unchanged, imem_req_o=0, fetch_cnt_o unchanged.
- Assert rst_i during FETCH while imem_ack_i=1 -> next cycle state IDLE, imem_addr_o=RESET_PC, instr_valid_o=0, fetch_cnt_o=0; PC at 32'hFFFF_FFFC without branch -> wraps to 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake,
// presents them to the decoder and steers the next PC from jump/branch results.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [5:0]  op_o,
    output logic [31:0] pc4_o,
    input  logic        jump_i,
    input  logic        branch_i,
    input  logic        zero_i,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc4_r;
    logic [31:0] instr_r;
    logic [31:0] fetch_cnt_r;
    logic [31:0] next_pc_s;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic        req_nxt_s;
    logic        valid_nxt_s;

    // Jump beats taken branch beats fall-through; all arithmetic wraps mod 2^32.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] pc4,
        input logic [31:0] instr,
        input logic        jump,
        input logic        branch,
        input logic        zero
    );
        logic [31:0] res;
        if (jump) begin
            res = {pc4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            res = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
        end else begin
            res = pc4;
        end
        return res;
    endfunction

    // State register and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            imem_req_r    <= req_nxt_s;
            instr_valid_r <= valid_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_ack_i) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            HOLD: begin
                if (instr_ready_i) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops present it in the state's own cycle.
    always_comb begin
        req_nxt_s   = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
            end
            FETCH: begin
                req_nxt_s   = 1'b1;
                valid_nxt_s = 1'b0;
            end
            HOLD: begin
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b1;
            end
            default: begin
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Next PC from the presented instruction and the decoder's verdict.
    always_comb begin
        next_pc_s = calc_next_pc(pc4_r, instr_r, jump_i, branch_i, zero_i);
    end

    // Datapath: capture on ack in FETCH, advance PC and count on accept in HOLD.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r        <= RESET_PC;
            pc4_r       <= 32'h0000_0000;
            instr_r     <= 32'h0000_0000;
            fetch_cnt_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                FETCH: begin
                    if (imem_ack_i) begin
                        instr_r <= imem_data_i;
                        pc4_r   <= pc_r + 32'd4;
                    end
                end
                HOLD: begin
                    if (instr_ready_i) begin
                        pc_r        <= next_pc_s;
                        fetch_cnt_r <= fetch_cnt_r + 32'd1;
                    end
                end
                default: begin
                    pc_r <= pc_r;
                end
            endcase
        end
    end

    assign imem_req_o    = imem_req_r;
    assign imem_addr_o   = pc_r;
    assign instr_valid_o = instr_valid_r;
    assign instr_o       = instr_r;
    assign op_o          = instr_r[31:26];
    assign pc4_o         = pc4_r;
    assign fetch_cnt_o   = fetch_cnt_r;

endmodule
